// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver; rejects start-bit glitches and flags stop-bit errors.
// Optional build macro UART_RX_MAJORITY_EN: each sample point uses a 3-sample majority vote.
module uart_rx #(
    parameter int SYS_CLOCK     = 50000000,
    parameter int UART_BAUDRATE = 115200
) (
    input  logic       i_SysClock,
    input  logic       i_Reset,
    input  logic       i_RxSerial,
    output logic [7:0] o_RxByte,
    output logic       o_RxValid,
    output logic       o_FrameErr,
    output logic       o_RxBusy
);

    localparam int MAX_CYCLE_CNT = ((SYS_CLOCK * 10 / UART_BAUDRATE + 5) / 10) - 1;
    localparam int HALF_CNT      = MAX_CYCLE_CNT / 2;
    localparam int CNT_W         = $clog2(MAX_CYCLE_CNT) + 1;

    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX_CYCLE_CNT);
    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(HALF_CNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           r_State;
    state_t           w_NextState;
    logic [CNT_W-1:0] r_Cnt;
    logic [CNT_W-1:0] w_NextCnt;
    logic [2:0]       r_BitCnt;
    logic [2:0]       w_NextBitCnt;
    logic [7:0]       r_Shift;
    logic [7:0]       w_NextShift;
    logic             w_SetValid;
    logic             w_SetErr;

    logic r_Sync1;
    logic r_Sync2;
    logic r_RxPrev;
    logic w_Fall;
    logic w_Sample;

    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            r_Sync1  <= 1'b1;
            r_Sync2  <= 1'b1;
            r_RxPrev <= 1'b1;
        end else begin
            r_Sync1  <= i_RxSerial;
            r_Sync2  <= r_Sync1;
            r_RxPrev <= r_Sync2;
        end
    end

    // Only a 1->0 transition arms a frame, so a line stuck low never re-triggers.
    assign w_Fall = r_RxPrev & ~r_Sync2;

`ifdef UART_RX_MAJORITY_EN
    logic r_RxPrev2;

    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            r_RxPrev2 <= 1'b1;
        end else begin
            r_RxPrev2 <= r_RxPrev;
        end
    end

    assign w_Sample = (r_Sync2 & r_RxPrev) | (r_Sync2 & r_RxPrev2) | (r_RxPrev & r_RxPrev2);
`else
    assign w_Sample = r_Sync2;
`endif

    always_comb begin
        w_NextState  = r_State;
        w_NextCnt    = '0;
        w_NextBitCnt = r_BitCnt;
        w_NextShift  = r_Shift;
        w_SetValid   = 1'b0;
        w_SetErr     = 1'b0;
        case (r_State)
            IDLE: begin
                if (w_Fall) begin
                    w_NextState = START;
                end
            end
            START: begin
                if (r_Cnt == C_HALF) begin
                    if (!w_Sample) begin
                        w_NextState  = DATA;
                        w_NextBitCnt = 3'd0;
                    end else begin
                        w_NextState = IDLE;
                    end
                end else begin
                    w_NextCnt = r_Cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (r_Cnt == C_MAX) begin
                    w_NextShift  = {w_Sample, r_Shift[7:1]};
                    w_NextBitCnt = r_BitCnt + 3'd1;
                    if (r_BitCnt == 3'd7) begin
                        w_NextState = STOP;
                    end
                end else begin
                    w_NextCnt = r_Cnt + CNT_W'(1);
                end
            end
            STOP: begin
                // Leave mid-stop-bit so an immediately following start edge is caught.
                if (r_Cnt == C_MAX) begin
                    w_NextState = IDLE;
                    if (w_Sample) begin
                        w_SetValid = 1'b1;
                    end else begin
                        w_SetErr = 1'b1;
                    end
                end else begin
                    w_NextCnt = r_Cnt + CNT_W'(1);
                end
            end
            default: begin
                w_NextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            r_State    <= IDLE;
            r_Cnt      <= '0;
            r_BitCnt   <= 3'd0;
            r_Shift    <= 8'h00;
            o_RxByte   <= 8'h00;
            o_RxValid  <= 1'b0;
            o_FrameErr <= 1'b0;
        end else begin
            r_State    <= w_NextState;
            r_Cnt      <= w_NextCnt;
            r_BitCnt   <= w_NextBitCnt;
            r_Shift    <= w_NextShift;
            o_RxValid  <= w_SetValid;
            o_FrameErr <= w_SetErr;
            if (w_SetValid) begin
                o_RxByte <= r_Shift;
            end
        end
    end

    assign o_RxBusy = (r_State != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenarios plus random frames, checked against a cycle-level
// reference model that decodes the logged pin waveform from the frame timing rules.
module tb_uart_rx;

    localparam int NMAX = 16384;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    uart_rx #(.SYS_CLOCK(16), .UART_BAUDRATE(1)) dut (
        .i_SysClock (clk),
        .i_Reset    (rst),
        .i_RxSerial (rx),
        .o_RxByte   (rx_byte),
        .o_RxValid  (rx_valid),
        .o_FrameErr (frame_err),
        .o_RxBusy   (rx_busy)
    );

    always #5 clk = ~clk;

    // cyc = number of the last rising edge; pin_log[e]/rst_log[e] = inputs seen at edge e,
    // *_log[c] = outputs during the cycle following edge c.
    int         cyc = 0;
    bit         pin_log  [NMAX];
    bit         rst_log  [NMAX];
    logic [7:0] byte_log [NMAX];
    logic       vld_log  [NMAX];
    logic       ferr_log [NMAX];
    logic       busy_log [NMAX];

    always @(posedge clk) begin
        if (cyc < NMAX - 1) begin
            pin_log[cyc+1] <= rx;
            rst_log[cyc+1] <= rst;
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (cyc < NMAX) begin
            byte_log[cyc] <= rx_byte;
            vld_log[cyc]  <= rx_valid;
            ferr_log[cyc] <= frame_err;
            busy_log[cyc] <= rx_busy;
        end
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One 8N1 frame, one pin value per cycle (16 cycles/bit). gk flips a single cycle,
    // rk aborts the frame at that cycle with a one-cycle reset and the line released high.
    task automatic send(input logic [7:0] b, input bit stop, input int gk, input int rk,
                        output int p);
        logic v;
        p = 0;
        for (int k = 0; k < 160; k++) begin
            @(negedge clk);
            if (k == 0) p = cyc + 1;
            if (k == rk) begin
                rx  = 1'b1;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (k < 16)       v = 1'b0;
            else if (k < 144) v = b[k/16 - 1];
            else              v = stop;
            rx = v ^ (k == gk);
        end
    endtask

    task automatic hold(input int n, input logic v);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = v;
        end
    endtask

    task automatic low_pulse(input int n, output int p);
        @(negedge clk);
        p  = cyc + 1;
        rx = 1'b0;
        repeat (n) @(negedge clk);
        rx = 1'b1;
    endtask

    function automatic int pulses(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++)
            if (vld_log[i] === 1'b1 || ferr_log[i] === 1'b1) n++;
        return n;
    endfunction

    // ---------------- reference model ----------------
    // Synchronized line value during cycle s: pin two edges back, forced high after a reset.
    function automatic bit rxs(input int s);
        if (s < 1) return 1'b1;
        if (rst_log[s] || rst_log[s-1]) return 1'b1;
        return pin_log[s-1];
    endfunction

    // Line value d cycles before cycle s, as remembered by the receiver (reset forgets history).
    function automatic bit hist(input int s, input int d);
        int t = s;
        for (int j = 0; j < d; j++) begin
            if (t < 1 || rst_log[t]) return 1'b1;
            t--;
        end
        return rxs(t);
    endfunction

    function automatic bit smp(input int s);
`ifdef UART_RX_MAJORITY_EN
        int ones = int'(hist(s, 0)) + int'(hist(s, 1)) + int'(hist(s, 2));
        return ones >= 2;
`else
        return hist(s, 0);
`endif
    endfunction

    function automatic int first_rst(input int a, input int b);
        for (int i = a; i <= b; i++) if (rst_log[i]) return i;
        return 0;
    endfunction

    bit         exp_busy [NMAX];
    bit         exp_vld  [NMAX];
    bit         exp_ferr [NMAX];
    logic [7:0] ev_byte  [NMAX];

    task automatic run_model(input int last);
        int c, r;
        logic [7:0] d;
        c = 4;
        while (c + 160 < last) begin
            if (!(hist(c, 1) && !hist(c, 0))) begin
                c++;
                continue;
            end
            r = first_rst(c + 1, c + 8);
            if (r != 0) begin
                for (int i = c + 1; i < r; i++) exp_busy[i] = 1'b1;
                c = r;
                continue;
            end
            if (smp(c + 8)) begin
                for (int i = c + 1; i <= c + 8; i++) exp_busy[i] = 1'b1;
                c = c + 9;
                continue;
            end
            r = first_rst(c + 9, c + 153);
            if (r != 0) begin
                for (int i = c + 1; i < r; i++) exp_busy[i] = 1'b1;
                c = r;
                continue;
            end
            for (int i = 0; i < 8; i++) d[i] = smp(c + 8 + 16 * (i + 1));
            for (int i = c + 1; i <= c + 152; i++) exp_busy[i] = 1'b1;
            if (smp(c + 152)) begin
                exp_vld[c+153] = 1'b1;
                ev_byte[c+153] = d;
            end else begin
                exp_ferr[c+153] = 1'b1;
            end
            c = c + 153;
        end
    endtask

    // ---------------- stimulus ----------------
    int p_nom, p_gl, p_fe, p_11, p_b0, p_b1, p_rs, p_5a, p_sg, p_tmp;
    int last, nb_busy, nb_byte, n_both, n_exp_ev, n_act_ev, gk, rk;
    logic [7:0] cur, exp_sg;

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_byte",  rx_byte,   8'h00);
        chk("reset_valid", rx_valid,  1'b0);
        chk("reset_ferr",  frame_err, 1'b0);
        chk("reset_busy",  rx_busy,   1'b0);

        hold(20, 1'b1);
        send(8'hA5, 1'b1, -1, -1, p_nom);
        hold(10, 1'b1);
        low_pulse(4, p_gl);
        hold(30, 1'b1);
        send(8'h3C, 1'b0, -1, -1, p_fe);
        hold(40, 1'b0);
        hold(10, 1'b1);
        send(8'h11, 1'b1, -1, -1, p_11);
        hold(10, 1'b1);
        send(8'h00, 1'b1, -1, -1, p_b0);
        send(8'hFF, 1'b1, -1, -1, p_b1);
        hold(10, 1'b1);
        send(8'hC3, 1'b1, -1, 88, p_rs);
        hold(200, 1'b1);
        send(8'h5A, 1'b1, -1, -1, p_5a);
        hold(10, 1'b1);
        send(8'h00, 1'b1, 56, -1, p_sg);
        hold(10, 1'b1);

        for (int f = 0; f < 40 && cyc < NMAX - 1200; f++) begin
            gk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 159)) : -1;
            rk = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 150)) : -1;
            send(8'($urandom), ($urandom_range(0, 7) != 0), gk, rk, p_tmp);
            if ($urandom_range(0, 5) == 0) begin
                hold(2, 1'b1);
                low_pulse($urandom_range(1, 6), p_tmp);
                hold(20, 1'b1);
            end
            hold($urandom_range(0, 30), rx);
            hold($urandom_range(0, 3), 1'b1);
        end
        hold(400, 1'b1);
        @(negedge clk);
        last = cyc;

        // directed scenario checks
        chk("nominal_valid",     vld_log[p_nom+154],  1'b1);
        chk("nominal_byte",      byte_log[p_nom+154], 8'hA5);
        chk("nominal_busy_pre",  busy_log[p_nom+153], 1'b1);
        chk("nominal_busy_drop", busy_log[p_nom+154], 1'b0);
        chk("nominal_no_ferr",   ferr_log[p_nom+154], 1'b0);

        nb_busy = 0;
        for (int i = p_gl; i < p_gl + 30; i++) if (busy_log[i] === 1'b1) nb_busy++;
        chk("start_glitch_busy_cycles", nb_busy, 8);
        chk("start_glitch_pulses", pulses(p_gl, p_gl + 30), 0);

        chk("frame_err_pulse",  ferr_log[p_fe+154], 1'b1);
        chk("frame_err_novld",  vld_log[p_fe+154],  1'b0);
        chk("frame_err_byte",   byte_log[p_fe+154], 8'hA5);
        chk("break_quiet",      pulses(p_fe + 155, p_11 - 1), 0);
        chk("after_break_vld",  vld_log[p_11+154],  1'b1);
        chk("after_break_byte", byte_log[p_11+154], 8'h11);

        chk("b2b_first_vld",   vld_log[p_b0+154],  1'b1);
        chk("b2b_first_byte",  byte_log[p_b0+154], 8'h00);
        chk("b2b_second_vld",  vld_log[p_b0+314],  1'b1);
        chk("b2b_second_byte", byte_log[p_b0+314], 8'hFF);
        chk("b2b_gap_quiet",   pulses(p_b0 + 155, p_b0 + 313), 0);

        chk("rst_mid_busy_pre",  busy_log[p_rs+87], 1'b1);
        chk("rst_mid_busy",      busy_log[p_rs+88], 1'b0);
        chk("rst_mid_byte",      byte_log[p_rs+88], 8'h00);
        chk("rst_mid_no_pulse",  pulses(p_rs, p_5a - 1), 0);
        chk("after_rst_vld",     vld_log[p_5a+154],  1'b1);
        chk("after_rst_byte",    byte_log[p_5a+154], 8'h5A);

`ifdef UART_RX_MAJORITY_EN
        exp_sg = 8'h00;
`else
        exp_sg = 8'h04;
`endif
        chk("sample_glitch_vld",  vld_log[p_sg+154],  1'b1);
        chk("sample_glitch_byte", byte_log[p_sg+154], exp_sg);

        // whole-run comparison against the reference model
        run_model(last);
        cur = 8'h00;
        nb_busy = 0; nb_byte = 0; n_both = 0; n_exp_ev = 0; n_act_ev = 0;
        for (int s = 1; s < last; s++) begin
            if (rst_log[s]) cur = 8'h00;
            else if (exp_vld[s]) cur = ev_byte[s];
            if (s < 4) continue;
            if (busy_log[s] !== exp_busy[s]) nb_busy++;
            if (byte_log[s] !== cur) nb_byte++;
            if (vld_log[s] === 1'b1 && ferr_log[s] === 1'b1) n_both++;
            if (exp_vld[s] || exp_ferr[s]) n_exp_ev++;
            if (vld_log[s] === 1'b1 || ferr_log[s] === 1'b1) n_act_ev++;
            if (exp_vld[s] || vld_log[s] !== 1'b0) begin
                chk("model_valid", vld_log[s], exp_vld[s]);
                if (exp_vld[s]) chk("model_byte", byte_log[s], ev_byte[s]);
            end
            if (exp_ferr[s] || ferr_log[s] !== 1'b0)
                chk("model_ferr", ferr_log[s], exp_ferr[s]);
        end
        chk("model_event_count", n_act_ev, n_exp_ev);
        chk("model_busy_trace", nb_busy, 0);
        chk("model_byte_trace", nb_byte, 0);
        chk("valid_and_ferr_together", n_both, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
